dm_sized_mc: RTL

Parametrised successor to the single-cycle data memory: a word-organised data RAM with byte, halfword and word loads and stores, plus sign or zero extension on loads.
- Adds a valid/ready request handshake, a configurable read latency and alignment/range error reporting.
- Reset no longer clears the whole array in one cycle; a sequential clear sweep does it, one word per cycle.
- Sits between the MEM stage and the memory array; emits the standard write trace line for every committed store.

---
 rtl/dm_sized_mc_if.sv | 37 +++
 rtl/dm_sized_mc.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dm_sized_mc_if.sv
`default_nettype none
// ============================================================================
// dm_sized_mc_if : request/response bundle for the sized data memory
// Revision 1.0
// ============================================================================
interface dm_sized_mc_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        clr_busy;
    // Store trace: valid for the cycle whose closing edge commits the store
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, clr_busy,
        input  trace_valid, trace_pc, trace_addr, trace_data
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, clr_busy,
        output trace_valid, trace_pc, trace_addr, trace_data
    );
endinterface
`default_nettype wire

// File: rtl/dm_sized_mc.sv
`default_nettype none
// ============================================================================
// dm_sized_mc : word-organised data RAM, sized loads/stores, valid/ready,
//               configurable read latency and a one-word-per-cycle clear sweep
// Revision 1.0
// ============================================================================
module dm_sized_mc #(
    parameter int          DEPTH_WORDS = 3072,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          RD_LAT      = 1
) (
    input  wire logic     clk,
    input  wire logic     reset,
    dm_sized_mc_if.slave  bus
);
    localparam int IW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int LAT_INIT = (RD_LAT > 1) ? RD_LAT - 2 : 0;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] clr_idx_q, clr_idx_d;
    logic [2:0]    lat_cnt_q, lat_cnt_d;
    logic [31:0]   pend_data_q, pend_data_d;
    logic          pend_err_q, pend_err_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [31:0]   word_off;
    logic [IW-1:0] word_idx;
    logic          dec_err;
    logic [31:0]   cur_word;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   load_val;
    logic [31:0]   wr_mask;
    logic [31:0]   wr_lane;
    logic [31:0]   merged_word;
    logic          accept;
    logic          mem_we;
    logic [IW-1:0] mem_widx;
    logic [31:0]   mem_wword;

    always_comb begin
        word_off = (bus.req_addr - BASE_ADDR) >> 2;
        word_idx = word_off[IW-1:0];
        dec_err  = (bus.req_addr < BASE_ADDR) || (word_off >= 32'(DEPTH_WORDS))
                 || (bus.req_size == 2'd3)
                 || ((bus.req_size == 2'd1) && bus.req_addr[0])
                 || ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));
        cur_word = dec_err ? 32'h0 : mem_q[word_idx];
        lane_b   = cur_word[{bus.req_addr[1:0], 3'b000} +: 8];
        lane_h   = bus.req_addr[1] ? cur_word[31:16] : cur_word[15:0];

        case (bus.req_size)
            2'd0:    load_val = {{24{lane_b[7] & ~bus.req_unsigned}}, lane_b};
            2'd1:    load_val = {{16{lane_h[15] & ~bus.req_unsigned}}, lane_h};
            default: load_val = cur_word;
        endcase

        case (bus.req_size)
            2'd0: begin
                wr_mask = 32'h0000_00FF << {bus.req_addr[1:0], 3'b000};
                wr_lane = {4{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                wr_mask = bus.req_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                wr_lane = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                wr_mask = 32'hFFFF_FFFF;
                wr_lane = bus.req_wdata;
            end
        endcase
        merged_word = (cur_word & ~wr_mask) | (wr_lane & wr_mask);
    end

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        lat_cnt_d   = lat_cnt_q;
        pend_data_d = pend_data_q;
        pend_err_d  = pend_err_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b0;
        accept      = 1'b0;
        mem_we      = 1'b0;
        mem_widx    = clr_idx_q;
        mem_wword   = 32'h0;

        case (state_q)
            S_CLEAR: begin
                mem_we = 1'b1;
                if (clr_idx_q == IW'(DEPTH_WORDS - 1)) begin
                    clr_idx_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (bus.req_valid) begin
                    accept      = 1'b1;
                    pend_err_d  = dec_err;
                    pend_data_d = 32'h0;
                    if (bus.req_we) begin
                        // Stores (and store errors) always answer one cycle later
                        mem_we    = ~dec_err;
                        mem_widx  = word_idx;
                        mem_wword = merged_word;
                        state_d   = S_RESP;
                    end else begin
                        if (!dec_err) pend_data_d = load_val;
                        if (RD_LAT > 1) begin
                            lat_cnt_d = 3'(LAT_INIT);
                            state_d   = S_WAIT;
                        end else begin
                            state_d   = S_RESP;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (lat_cnt_q == 3'd0) state_d = S_RESP;
                else                   lat_cnt_d = lat_cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_RESP) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = pend_data_d;
            rsp_err_d   = pend_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_CLEAR;
            clr_idx_q   <= '0;
            lat_cnt_q   <= 3'd0;
            pend_data_q <= 32'h0;
            pend_err_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            lat_cnt_q   <= lat_cnt_d;
            pend_data_q <= pend_data_d;
            pend_err_q  <= pend_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // The array is not reset: contents survive until the sweep reaches them
    always_ff @(posedge clk) begin
        if (reset && mem_we) mem_q[mem_widx] <= mem_wword;
    end

    assign bus.req_ready   = reset && (state_q == S_IDLE);
    assign bus.clr_busy    = !reset || (state_q == S_CLEAR);
    assign bus.rsp_valid   = reset && rsp_valid_q;
    assign bus.rsp_rdata   = reset ? rsp_rdata_q : 32'h0;
    assign bus.rsp_err     = reset && rsp_err_q;

    assign bus.trace_valid = reset && accept && bus.req_we && !dec_err;
    assign bus.trace_pc    = bus.req_pc;
    assign bus.trace_addr  = bus.req_addr & ~32'h3;
    assign bus.trace_data  = merged_word;
endmodule
`default_nettype wire
